// File: rtl/hdmi_frame_sched_pkg.sv
// Purpose: shared encodings for the HDMI frame scheduler (FSM states, buffer status, timeout default).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdmi_frame_sched_pkg;

    // FSM state encoding, kept as plain constants so the state port stays a raw 2-bit value
    localparam logic [1:0] ST_WAIT_CFG   = 2'd0;
    localparam logic [1:0] ST_WAIT_RX    = 2'd1;
    localparam logic [1:0] ST_WAIT_VIDEO = 2'd2;
    localparam logic [1:0] ST_RUN        = 2'd3;

    // Per-buffer ownership status
    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_READING = 2'd3
    } buf_st_t;

    // Default allowed gap between frame starts while running (100 ms at 100 MHz)
    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd10_000_000;

endpackage

// File: rtl/hdmi_frame_sched_pp_buf_tracker.sv
// Purpose: ping-pong buffer ownership tracker (writer target selection, reader grants, drop detection).
// Latency: wr_start/rd_grant registered one cycle after the triggering event; drop_evt is combinational.
// Backpressure: none; events arriving while the resource is busy are ignored or reported as drops.
//
// Ports: en       - tracker active (FSM in RUN and staying there); low clears all ownership
//        vs_pulse/wr_done/rd_req/rd_done - event pulses from the video path
//        wr_start/wr_buf/wr_active       - writer control
//        rd_grant/rd_buf                 - reader control
//        drop_evt - a frame is lost this cycle (registered by the top level)
module pp_buf_tracker
    import hdmi_frame_sched_pkg::*;
(
    input  logic iclk,
    input  logic s_rst_n,
    input  logic en,
    input  logic vs_pulse,
    input  logic wr_done,
    input  logic rd_req,
    input  logic rd_done,
    output logic wr_start,
    output logic wr_buf,
    output logic wr_active,
    output logic rd_grant,
    output logic rd_buf,
    output logic drop_evt
);

    buf_st_t st_q [2];
    buf_st_t st_n [2];
    logic    latest_q, latest_n;
    // latest only points at real data once a frame has completed; before that, write buffer 0
    logic    latest_vld_q, latest_vld_n;
    logic    pend_q, pend_n;
    logic    wr_start_n, wr_buf_n, wr_active_n, rd_grant_n, rd_buf_n;
    logic    rd_busy;
    logic    tgt;

    assign rd_busy = (st_q[0] == BUF_READING) || (st_q[1] == BUF_READING);

    always_comb begin
        st_n         = st_q;
        latest_n     = latest_q;
        latest_vld_n = latest_vld_q;
        pend_n       = pend_q;
        wr_start_n   = 1'b0;
        wr_buf_n     = wr_buf;
        wr_active_n  = wr_active;
        rd_grant_n   = 1'b0;
        rd_buf_n     = rd_buf;
        drop_evt     = 1'b0;
        tgt          = 1'b0;

        if (!en) begin
            st_n[0]      = BUF_EMPTY;
            st_n[1]      = BUF_EMPTY;
            latest_n     = 1'b0;
            latest_vld_n = 1'b0;
            pend_n       = 1'b0;
            wr_buf_n     = 1'b0;
            wr_active_n  = 1'b0;
            rd_buf_n     = 1'b0;
        end else begin
            // reader release first so a freed buffer is a legal write target this cycle
            if (rd_done && (st_q[rd_buf] == BUF_READING))
                st_n[rd_buf] = BUF_EMPTY;

            if (wr_done && wr_active) begin
                st_n[wr_buf] = BUF_FULL;
                latest_n     = wr_buf;
                latest_vld_n = 1'b1;
                wr_active_n  = 1'b0;
            end

            // the writer-busy decision uses the registered wr_active
            if (vs_pulse) begin
                if (wr_active) begin
                    drop_evt = 1'b1;
                end else begin
                    if (!latest_vld_q)
                        tgt = 1'b0;
                    else if (st_n[~latest_q] != BUF_READING)
                        tgt = ~latest_q;
                    else
                        tgt = latest_q;
                    if (st_n[tgt] == BUF_FULL)
                        drop_evt = 1'b1;
                    st_n[tgt]   = BUF_WRITING;
                    wr_active_n = 1'b1;
                    wr_buf_n    = tgt;
                    wr_start_n  = 1'b1;
                end
            end

            if (rd_req && !rd_busy)
                pend_n = 1'b1;

            // grant looks at post-completion status so a same-cycle wr_done is served immediately
            if (pend_q && (st_n[latest_n] == BUF_FULL)) begin
                st_n[latest_n] = BUF_READING;
                rd_buf_n       = latest_n;
                rd_grant_n     = 1'b1;
                pend_n         = 1'b0;
            end
        end
    end

    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            st_q[0]      <= BUF_EMPTY;
            st_q[1]      <= BUF_EMPTY;
            latest_q     <= 1'b0;
            latest_vld_q <= 1'b0;
            pend_q       <= 1'b0;
            wr_start     <= 1'b0;
            wr_buf       <= 1'b0;
            wr_active    <= 1'b0;
            rd_grant     <= 1'b0;
            rd_buf       <= 1'b0;
        end else begin
            st_q         <= st_n;
            latest_q     <= latest_n;
            latest_vld_q <= latest_vld_n;
            pend_q       <= pend_n;
            wr_start     <= wr_start_n;
            wr_buf       <= wr_buf_n;
            wr_active    <= wr_active_n;
            rd_grant     <= rd_grant_n;
            rd_buf       <= rd_buf_n;
        end
    end

endmodule

// File: rtl/hdmi_frame_sched.sv
// Purpose: HDMI frame scheduler: bring-up FSM, frame-gap timeout, drop counting around a ping-pong tracker.
// Latency: all control pulses registered, one cycle after the triggering input.
// Backpressure: none; busy conditions turn incoming frames into frame_drop pulses.
//
// Ports: iclk/s_rst_n - clock, async active-low reset
//        cfg_done/rx_over/video_en - bring-up handshakes
//        vs_pulse/wr_done/rd_req/rd_done - per-frame events
//        wr_start/wr_buf/wr_active/rd_grant/rd_buf - buffer handoff
//        frame_drop/drop_cnt/state/timeout_err - status
module hdmi_frame_sched
    import hdmi_frame_sched_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned DCNT_W      = 16
) (
    input  logic              iclk,
    input  logic              s_rst_n,
    input  logic              cfg_done,
    input  logic              rx_over,
    input  logic              video_en,
    input  logic              vs_pulse,
    input  logic              wr_done,
    input  logic              rd_req,
    input  logic              rd_done,
    output logic              wr_start,
    output logic              wr_buf,
    output logic              wr_active,
    output logic              rd_grant,
    output logic              rd_buf,
    output logic              frame_drop,
    output logic [DCNT_W-1:0] drop_cnt,
    output logic [1:0]        state,
    output logic              timeout_err
);

    logic [1:0]  nxt_state;
    logic        rx_seen_q;
    logic [23:0] gap_cnt;
    logic        gap_hit;
    logic        trk_en;
    logic        drop_evt;

    // gap_cnt counts completed vs-less RUN cycles; this cycle would be number TIMEOUT_CYC
    assign gap_hit = (state == ST_RUN) && !vs_pulse && (gap_cnt == TIMEOUT_CYC - 24'd1);

    always_comb begin
        nxt_state = state;
        if (!cfg_done) begin
            nxt_state = ST_WAIT_CFG;
        end else begin
            case (state)
                ST_WAIT_CFG:   nxt_state = ST_WAIT_RX;
                ST_WAIT_RX:    if (rx_seen_q || rx_over) nxt_state = ST_WAIT_VIDEO;
                ST_WAIT_VIDEO: if (video_en) nxt_state = ST_RUN;
                default:       if (gap_hit) nxt_state = ST_WAIT_VIDEO;
            endcase
        end
    end

    // Leaving RUN drops every event of that cycle, so no pulse can appear outside RUN
    assign trk_en = (state == ST_RUN) && (nxt_state == ST_RUN);

    pp_buf_tracker u_trk (
        .iclk      (iclk),
        .s_rst_n   (s_rst_n),
        .en        (trk_en),
        .vs_pulse  (vs_pulse),
        .wr_done   (wr_done),
        .rd_req    (rd_req),
        .rd_done   (rd_done),
        .wr_start  (wr_start),
        .wr_buf    (wr_buf),
        .wr_active (wr_active),
        .rd_grant  (rd_grant),
        .rd_buf    (rd_buf),
        .drop_evt  (drop_evt)
    );

    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= ST_WAIT_CFG;
            rx_seen_q   <= 1'b0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            frame_drop  <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= nxt_state;
            rx_seen_q   <= rx_seen_q | rx_over;
            gap_cnt     <= ((state == ST_RUN) && !vs_pulse && !gap_hit) ? gap_cnt + 24'd1 : '0;
            timeout_err <= timeout_err | gap_hit;
            frame_drop  <= drop_evt;
            if (drop_evt && !(&drop_cnt))
                drop_cnt <= drop_cnt + DCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hdmi_frame_sched.sv
// Purpose: self-checking bench for hdmi_frame_sched: directed scenarios plus randomized traffic vs a model.
// Latency: model predicts outputs visible one clock after each input set.
// Backpressure: n/a.
module tb_hdmi_frame_sched;

    localparam int TMO  = 100;
    localparam int DW   = 4;
    localparam int DMAX = 15;
    localparam int EMPTY = 0, WRITING = 1, FULL = 2, READING = 3;

    logic          iclk = 1'b0;
    logic          s_rst_n, cfg_done, rx_over, video_en;
    logic          vs_pulse, wr_done, rd_req, rd_done;
    logic          wr_start, wr_buf, wr_active, rd_grant, rd_buf, frame_drop;
    logic [DW-1:0] drop_cnt;
    logic [1:0]    state;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_state, m_rx, m_gap, m_terr, m_dcnt;
    int m_latest, m_have, m_pend, m_wact, m_wbuf, m_rbuf;
    int m_wstart, m_grant, m_drop;
    int m_b [2];

    always #5 iclk = ~iclk;

    hdmi_frame_sched #(.TIMEOUT_CYC(24'd100), .DCNT_W(DW)) dut (
        .iclk        (iclk),
        .s_rst_n     (s_rst_n),
        .cfg_done    (cfg_done),
        .rx_over     (rx_over),
        .video_en    (video_en),
        .vs_pulse    (vs_pulse),
        .wr_done     (wr_done),
        .rd_req      (rd_req),
        .rd_done     (rd_done),
        .wr_start    (wr_start),
        .wr_buf      (wr_buf),
        .wr_active   (wr_active),
        .rd_grant    (rd_grant),
        .rd_buf      (rd_buf),
        .frame_drop  (frame_drop),
        .drop_cnt    (drop_cnt),
        .state       (state),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rx = 0; m_gap = 0; m_terr = 0; m_dcnt = 0;
        m_latest = 0; m_have = 0; m_pend = 0; m_wact = 0; m_wbuf = 0; m_rbuf = 0;
        m_wstart = 0; m_grant = 0; m_drop = 0;
        m_b = '{EMPTY, EMPTY};
    endtask

    // Apply the rules to the inputs currently driven; result is what the DUT shows after the next edge.
    task automatic model_step();
        int nst;
        int tgt;
        bit to;
        bit in_run;
        bit was_reading;
        bit pend_before;
        bit wact_before;
        in_run = (m_state == 3);
        to = 0;
        if (in_run) begin
            if (vs_pulse) m_gap = 0;
            else begin
                m_gap++;
                if (m_gap >= TMO) begin
                    to = 1;
                    m_gap = 0;
                end
            end
        end else m_gap = 0;

        if (!cfg_done) nst = 0;
        else begin
            case (m_state)
                0:       nst = 1;
                1:       nst = (m_rx != 0 || rx_over) ? 2 : 1;
                2:       nst = video_en ? 3 : 2;
                default: nst = to ? 2 : 3;
            endcase
        end
        if (rx_over) m_rx = 1;
        if (to) m_terr = 1;

        m_wstart = 0; m_grant = 0; m_drop = 0;
        if (in_run && nst == 3) begin
            was_reading = (m_b[0] == READING) || (m_b[1] == READING);
            pend_before = (m_pend != 0);
            wact_before = (m_wact != 0);
            if (rd_done)
                for (int i = 0; i < 2; i++) if (m_b[i] == READING) m_b[i] = EMPTY;
            if (wr_done && wact_before) begin
                for (int i = 0; i < 2; i++)
                    if (m_b[i] == WRITING) begin
                        m_b[i] = FULL; m_latest = i; m_have = 1;
                    end
                m_wact = 0;
            end
            if (vs_pulse) begin
                if (wact_before) m_drop = 1;
                else begin
                    if (m_have == 0) tgt = 0;
                    else if (m_b[1 - m_latest] != READING) tgt = 1 - m_latest;
                    else tgt = m_latest;
                    if (m_b[tgt] == FULL) m_drop = 1;
                    m_b[tgt] = WRITING; m_wact = 1; m_wbuf = tgt; m_wstart = 1;
                end
            end
            if (rd_req && !was_reading) m_pend = 1;
            if (pend_before && m_b[m_latest] == FULL) begin
                m_b[m_latest] = READING; m_rbuf = m_latest; m_grant = 1; m_pend = 0;
            end
            if (m_drop != 0) m_dcnt = (m_dcnt == DMAX) ? DMAX : m_dcnt + 1;
        end else begin
            m_b = '{EMPTY, EMPTY};
            m_latest = 0; m_have = 0; m_pend = 0; m_wact = 0; m_wbuf = 0; m_rbuf = 0;
        end
        m_state = nst;
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("wr_start", wr_start, m_wstart);
        chk("wr_buf", wr_buf, m_wbuf);
        chk("wr_active", wr_active, m_wact);
        chk("rd_grant", rd_grant, m_grant);
        chk("rd_buf", rd_buf, m_rbuf);
        chk("frame_drop", frame_drop, m_drop);
        chk("drop_cnt", drop_cnt, m_dcnt);
        chk("timeout_err", timeout_err, m_terr);
    endtask

    task automatic tick();
        model_step();
        @(posedge iclk);
        #1;
        check_all();
    endtask

    task automatic clr_inputs();
        cfg_done = 0; rx_over = 0; video_en = 0;
        vs_pulse = 0; wr_done = 0; rd_req = 0; rd_done = 0;
    endtask

    task automatic do_reset();
        s_rst_n = 0;
        clr_inputs();
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge iclk);
        #1;
        check_all();
        s_rst_n = 1;
    endtask

    task automatic startup();
        do_reset();
        cfg_done = 1;
        tick();
        chk("start_st1", state, 1);
        chk("start_no_wr", wr_start, 0);
        rx_over = 1;
        tick();
        rx_over = 0;
        chk("start_st2", state, 2);
        chk("start_no_wr2", wr_start, 0);
        video_en = 1;
        tick();
        chk("start_st3", state, 3);
    endtask

    task automatic step(input bit v, input bit w, input bit q, input bit d);
        vs_pulse = v; wr_done = w; rd_req = q; rd_done = d;
        tick();
        vs_pulse = 0; wr_done = 0; rd_req = 0; rd_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        s_rst_n = 0;
        clr_inputs();
        model_reset();
        #1;
        chk("rst_state", state, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_wr_active", wr_active, 0);

        // ping-pong, no reads
        startup();
        step(1, 0, 0, 0);
        chk("pp1_start", wr_start, 1);
        chk("pp1_buf", wr_buf, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("pp2_buf", wr_buf, 1);
        chk("pp2_nodrop", frame_drop, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("pp3_buf", wr_buf, 0);
        chk("pp3_drop", frame_drop, 1);
        chk("pp3_cnt", drop_cnt, 1);
        step(0, 1, 0, 0);

        // reader holds buffer 0 while two frames arrive
        startup();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("rh_no_early_grant", rd_grant, 0);
        step(0, 0, 0, 0);
        chk("rh_grant", rd_grant, 1);
        chk("rh_rd_buf", rd_buf, 0);
        step(1, 0, 0, 0);
        chk("rh_w1_buf", wr_buf, 1);
        chk("rh_w1_nodrop", frame_drop, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("rh_w2_buf", wr_buf, 1);
        chk("rh_w2_drop", frame_drop, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("rh_freed_buf", wr_buf, 0);
        chk("rh_freed_nodrop", frame_drop, 0);
        step(0, 1, 0, 0);

        // busy writer
        step(1, 0, 0, 0);
        chk("busy_first_buf", wr_buf, 1);
        step(1, 0, 0, 0);
        chk("busy_drop", frame_drop, 1);
        chk("busy_nostart", wr_start, 0);
        chk("busy_wrbuf", wr_buf, 1);
        chk("busy_active", wr_active, 1);
        step(0, 1, 0, 0);

        // timeout after 100 vs-less cycles
        startup();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        n = 1;
        while (timeout_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 100);
        chk("to_state", state, 2);
        tick();
        chk("to_rerun", state, 3);
        step(1, 0, 0, 0);
        chk("to_empty_buf", wr_buf, 0);
        chk("to_empty_nodrop", frame_drop, 0);
        chk("to_sticky", timeout_err, 1);
        step(0, 1, 0, 0);

        // abort during write, latch of rx_over kept
        startup();
        step(1, 0, 0, 0);
        chk("ab_active", wr_active, 1);
        cfg_done = 0;
        tick();
        chk("ab_state", state, 0);
        chk("ab_inactive", wr_active, 0);
        step(0, 1, 0, 0);
        chk("ab_wd_ignored", wr_active, 0);
        cfg_done = 1;
        tick();
        tick();
        chk("ab_rx_kept", state, 2);
        tick();
        chk("ab_run", state, 3);
        step(1, 0, 0, 0);
        chk("ab_fresh_buf", wr_buf, 0);

        // reset in the middle of a frame
        #3;
        s_rst_n = 0;
        #1;
        chk("mr_state", state, 0);
        chk("mr_inactive", wr_active, 0);
        chk("mr_nostart", wr_start, 0);
        clr_inputs();
        model_reset();
        check_all();
        @(posedge iclk);
        #1;
        s_rst_n = 1;

        // randomized traffic
        startup();
        for (int i = 0; i < 3000; i++) begin
            vs_pulse = ($urandom_range(5) == 0);
            if ((i % 1000) >= 850 && (i % 1000) < 980) vs_pulse = 0;
            wr_done  = ($urandom_range(3) == 0);
            rd_req   = ($urandom_range(4) == 0);
            rd_done  = ($urandom_range(4) == 0);
            rx_over  = ($urandom_range(50) == 0);
            cfg_done = ($urandom_range(400) != 0);
            video_en = ($urandom_range(200) != 0);
            tick();
        end
        clr_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_frame_sched.md
HDMI_FRAME_SCHED -- requirements
Module: hdmi_frame_sched

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT_CYC, default 24'd10_000_000, iclk cycles allowed between vs_pulse in RUN.
- DCNT_W, default 16, drop_cnt width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- iclk  in  1  system clock.
- s_rst_n  in  1  reset, asynchronous, active-low.
- cfg_done  in  1  level, receiver configuration complete.
- rx_over  in  1  pulse, host parameter load complete.
- video_en  in  1  level, video playback started; already synchronised to iclk.
- vs_pulse  in  1  one-cycle frame-start pulse, synchronised to iclk.
- wr_done  in  1  pulse, frame writer finished current buffer.
- rd_req  in  1  pulse, tracker requests a frame.
- rd_done  in  1  pulse, tracker finished reading granted buffer.
- wr_start  out  1  pulse, writer starts filling wr_buf.
- wr_buf  out  1  buffer index for writer.
- wr_active  out  1  level, write in progress.
- rd_grant  out  1  pulse, buffer rd_buf handed to tracker.
- rd_buf  out  1  buffer index for reader.
- frame_drop  out  1  pulse, one frame lost.
- drop_cnt  out  DCNT_W  saturating count of dropped frames.
- state  out  2  current FSM state encoding.
- timeout_err  out  1  sticky, missing-frame error.

Function
REQ-003 FSM states SHALL be WAIT_CFG=0, WAIT_RX=1, WAIT_VIDEO=2, RUN=3.
REQ-004 Transitions SHALL be:
- WAIT_CFG->WAIT_RX when cfg_done=1.
- WAIT_RX->WAIT_VIDEO when rx_over has been seen (sticky latch, set by a pulse in any state).
- WAIT_VIDEO->RUN when video_en=1.
REQ-005 cfg_done=0 in any state SHALL force WAIT_CFG next cycle; the rx_over latch is kept.
REQ-006 On entering WAIT_CFG from RUN, all buffers SHALL go EMPTY, wr_active=0, read ownership SHALL be cleared, and no pulse SHALL be emitted.
REQ-007 Each of two buffers SHALL hold a status EMPTY, WRITING, FULL or READING; a register "latest" SHALL hold the index of the most recently completed FULL buffer.
REQ-008 In RUN, vs_pulse with wr_active=0 SHALL assert wr_start for one cycle on the next cycle, set wr_active=1, and mark target WRITING.
REQ-009 Target selection SHALL be:
- ~latest if that buffer is not READING;
- otherwise latest.
REQ-010 Overwriting a FULL buffer SHALL pulse frame_drop in the same cycle as wr_start.
REQ-011 vs_pulse with wr_active=1 SHALL be ignored for writing and SHALL pulse frame_drop on the next cycle.
REQ-012 wr_done SHALL mark the WRITING buffer FULL, set latest to it, and clear wr_active next cycle; wr_done with wr_active=0 SHALL be ignored.
REQ-013 rd_req SHALL set a pending flag when no buffer is READING; rd_req while a buffer is READING SHALL be ignored.
REQ-014 Pending with buffer latest FULL SHALL assert rd_grant one cycle later with rd_buf=latest, mark it READING, and clear pending.
REQ-015 rd_done SHALL mark the READING buffer EMPTY; rd_done with no buffer READING SHALL be ignored.
REQ-016 Simultaneous events SHALL resolve as follows:
- wr_done and pending in the same cycle: grant on the following cycle using the newly FULL buffer.
- rd_done and vs_pulse in the same cycle: the freed buffer is eligible as target.
REQ-017 drop_cnt SHALL increment by 1 per frame_drop and saturate at all-ones.
REQ-018 In RUN, a frame-gap counter SHALL clear on vs_pulse and increment otherwise; reaching TIMEOUT_CYC SHALL set timeout_err and move the FSM to WAIT_VIDEO with the REQ-006 cleanup.
REQ-019 timeout_err SHALL clear only on reset.
REQ-020 wr_start, rd_grant and frame_drop SHALL be registered one-cycle pulses, never asserted outside RUN.

Reset
REQ-021 The following SHALL be 0 while s_rst_n=0: state (WAIT_CFG), all outputs, the rx_over latch, pending, latest, the gap counter and drop_cnt; all buffers SHALL be EMPTY.
REQ-022 Reset assertion mid-frame SHALL abandon all ownership immediately, with no completion pulses.

Structure
REQ-023 A shared package SHALL hold:
- the FSM state encoding;
- the buffer-status encoding;
- the TIMEOUT_CYC default.
REQ-024 Buffer status and selection SHALL sit in one sub-module, pp_buf_tracker; the FSM, timeout and drop counting SHALL stay in the top level.

Verification
REQ-025 Startup: cfg_done=1, rx_over pulse, video_en=1 -> state steps 0,1,2,3; no wr_start before RUN.
REQ-026 Ping-pong: three vs_pulse/wr_done pairs, no reads -> wr_buf 0,1,0; frame_drop on the third wr_start; drop_cnt=1.
REQ-027 Reader hold:
- grant buffer 0, hold rd_done;
- two more frames arrive -> both write buffer 1, second one drops;
- rd_done -> buffer 0 EMPTY.
REQ-028 Busy writer: vs_pulse while wr_active=1 -> frame_drop one cycle later, no wr_start, wr_buf unchanged.
REQ-029 Timeout: TIMEOUT_CYC=100, no vs_pulse for 100 cycles in RUN -> timeout_err=1, state=2, buffers EMPTY.
REQ-030 Abort: cfg_done deasserted during a write -> state=0 next cycle, wr_active=0, later wr_done ignored.
